alu_operand_sel_pipe: RTL and testbench

- Parametrised successor to the datapath's fixed 3-way ALU source-A selector.
- Selects one of N_INPUTS word-wide datapath sources, or one of two built-in constants (zero, CONST_VAL), as an ALU operand.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the multicycle control unit can stall the ALU stage without losing operands.
- Flags and counts illegal selector codes.

---
 rtl/alu_operand_sel_pipe.sv | 104 ++++++++++
 tb/tb_alu_operand_sel_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sel_pipe.sv
// ALU operand selector: picks a datapath source or built-in constant and
// registers it behind a valid/ready handshake with a 2-entry skid buffer.
module alu_operand_sel_pipe #(
   parameter int WIDTH     = 32,
   parameter int N_INPUTS  = 2,
   parameter int SEL_W     = 4,
   parameter int CONST_VAL = 4,
   parameter int ERR_W     = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [SEL_W-1:0]          seletor,
   input  logic [N_INPUTS*WIDTH-1:0] data_in,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      sel_error,
   output logic [ERR_W-1:0]          err_count
);

   localparam logic [WIDTH-1:0] CONST_WORD = WIDTH'(CONST_VAL);

   logic [WIDTH-1:0] head_data;
   logic             head_valid;
   logic [WIDTH-1:0] skid_data;
   logic             skid_valid;
   logic             sel_error_q;
   logic [ERR_W-1:0] err_count_q;

   logic [WIDTH-1:0] sel_word;
   logic             sel_illegal;
   logic             accept;
   logic             consume;

   // Illegal codes default to a zero word so unused slots never leak out.
   always_comb begin
      sel_word    = '0;
      sel_illegal = 1'b1;
      for (int k = 0; k < N_INPUTS; k++) begin
         if (seletor == SEL_W'(k)) begin
            sel_word    = data_in[k*WIDTH +: WIDTH];
            sel_illegal = 1'b0;
         end
      end
      if (seletor == SEL_W'(N_INPUTS)) begin
         sel_illegal = 1'b0;
      end
      if (seletor == SEL_W'(N_INPUTS + 1)) begin
         sel_word    = CONST_WORD;
         sel_illegal = 1'b0;
      end
   end

   assign in_ready  = ~skid_valid;
   assign out_valid = head_valid;
   assign out_data  = head_data;
   assign sel_error = sel_error_q;
   assign err_count = err_count_q;

   assign accept  = in_valid & in_ready;
   assign consume = head_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_data   <= '0;
         head_valid  <= 1'b0;
         skid_data   <= '0;
         skid_valid  <= 1'b0;
         sel_error_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         sel_error_q <= accept & sel_illegal;
         if (accept && sel_illegal && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_q <= err_count_q + 1'b1;
         end

         if (flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
         end else if (consume && skid_valid) begin
            // in_ready is low here, so no accept can collide with the shift.
            head_data  <= skid_data;
            skid_valid <= 1'b0;
         end else if (consume) begin
            head_valid <= accept;
            if (accept) begin
               head_data <= sel_word;
            end
         end else if (accept) begin
            if (!head_valid) begin
               head_data  <= sel_word;
               head_valid <= 1'b1;
            end else begin
               skid_data  <= sel_word;
               skid_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_sel_pipe.sv
// Directed plus randomised bench for alu_operand_sel_pipe (default parameters).
module tb_alu_operand_sel_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [3:0]  seletor;
   logic [63:0] data_in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        sel_error;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] sb[$];

   alu_operand_sel_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .seletor   (seletor),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel_error (sel_error),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] s, input logic [63:0] d);
      case (s)
         4'd0:    return d[31:0];
         4'd1:    return d[63:32];
         4'd2:    return 32'h0;
         4'd3:    return 32'h4;
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      reset = 1'b0; flush = 1'b0; seletor = '0; data_in = '0;
      in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_sel_error", 32'(sel_error), 32'h0);
      chk("rst_err_count", 32'(err_count), 32'h0);
      reset = 1'b1;

      // Basic selection, one accept per cycle, consumed immediately
      data_in = {32'hDEADBEEF, 32'h00400010};
      out_ready = 1'b1; in_valid = 1'b1;
      seletor = 4'd0; tick();
      chk("sel0_valid", 32'(out_valid), 32'h1);
      chk("sel0_data", out_data, 32'h00400010);
      seletor = 4'd1; tick();
      chk("sel1_data", out_data, 32'hDEADBEEF);
      chk("sel1_err", 32'(sel_error), 32'h0);
      seletor = 4'd2; tick();
      chk("sel2_data", out_data, 32'h0);
      seletor = 4'd3; tick();
      chk("sel3_data", out_data, 32'h4);
      chk("sel3_err", 32'(sel_error), 32'h0);

      // Illegal codes and counter saturation
      seletor = 4'd5; tick();
      chk("ill_valid", 32'(out_valid), 32'h1);
      chk("ill_data", out_data, 32'h0);
      chk("ill_pulse", 32'(sel_error), 32'h1);
      chk("ill_count1", 32'(err_count), 32'h1);
      in_valid = 1'b0; tick();
      chk("ill_pulse_end", 32'(sel_error), 32'h0);
      chk("drain_valid", 32'(out_valid), 32'h0);
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         seletor = 4'(4 + (i % 12));
         tick();
         if (i == 253) chk("sat_reach", 32'(err_count), 32'd255);
      end
      chk("sat_hold", 32'(err_count), 32'd255);
      chk("sat_pulse", 32'(sel_error), 32'h1);
      in_valid = 1'b0; tick();

      // Skid: hold out_ready low while two words arrive
      out_ready = 1'b0; in_valid = 1'b1; seletor = 4'd0;
      data_in = {32'h0, 32'h11}; tick();
      chk("w0_valid", 32'(out_valid), 32'h1);
      chk("w0_data", out_data, 32'h11);
      chk("w0_ready", 32'(in_ready), 32'h1);
      data_in = {32'h0, 32'h22}; tick();
      chk("w1_hold", out_data, 32'h11);
      chk("w1_ready", 32'(in_ready), 32'h0);
      in_valid = 1'b0; tick();
      chk("stall_hold", out_data, 32'h11);
      chk("stall_ready", 32'(in_ready), 32'h0);
      out_ready = 1'b1; tick();
      chk("skid_data", out_data, 32'h22);
      chk("skid_valid", 32'(out_valid), 32'h1);
      chk("skid_ready", 32'(in_ready), 32'h1);
      tick();
      chk("skid_empty", 32'(out_valid), 32'h0);

      // Flush with both entries full and an offer pending
      out_ready = 1'b0; in_valid = 1'b1;
      data_in = {32'h0, 32'h44}; tick();
      data_in = {32'h0, 32'h55}; tick();
      chk("pre_flush_ready", 32'(in_ready), 32'h0);
      flush = 1'b1; data_in = {32'h0, 32'h33}; tick();
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_ready", 32'(in_ready), 32'h1);
      flush = 1'b0; in_valid = 1'b0; tick();
      chk("flush_stay", 32'(out_valid), 32'h0);
      // Flush discarding a word that is actually accepted
      in_valid = 1'b1; data_in = {32'h0, 32'h66}; tick();
      flush = 1'b1; data_in = {32'h0, 32'h33}; tick();
      chk("flush2_valid", 32'(out_valid), 32'h0);
      chk("flush2_ready", 32'(in_ready), 32'h1);
      flush = 1'b0; in_valid = 1'b0; tick();
      chk("flush2_stay", 32'(out_valid), 32'h0);
      out_ready = 1'b1; in_valid = 1'b1; data_in = {32'h0, 32'h77}; tick();
      chk("post_flush_data", out_data, 32'h77);
      in_valid = 1'b0; tick();

      // Reset mid-stream with skid full and an illegal offer pending
      out_ready = 1'b0; in_valid = 1'b1; seletor = 4'd0;
      data_in = {32'h0, 32'h88}; tick();
      data_in = {32'h0, 32'h99}; tick();
      seletor = 4'd7; reset = 1'b0; tick();
      chk("mrst_valid", 32'(out_valid), 32'h0);
      chk("mrst_data", out_data, 32'h0);
      chk("mrst_ready", 32'(in_ready), 32'h1);
      chk("mrst_err", 32'(sel_error), 32'h0);
      chk("mrst_count", 32'(err_count), 32'h0);
      reset = 1'b1; in_valid = 1'b0; tick();

      // Random traffic against a FIFO scoreboard
      for (int c = 0; c < 10000; c++) begin
         logic ir0;
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         seletor   = 4'($urandom_range(0, 3));
         data_in   = {$urandom, $urandom};
         ir0 = in_ready;
         out_ready = ~out_ready;
         #1;
         if ((c % 50) == 0) chk("no_comb_path", 32'(in_ready), 32'(ir0));
         out_ready = ~out_ready;
         #1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("rand_unexpected", out_data, 32'hFFFF_FFFF);
            else chk("rand_order", out_data, sb.pop_front());
         end
         if (in_valid && in_ready) sb.push_back(model(seletor, data_in));
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10 && sb.size() > 0; c++) begin
         #1;
         if (out_valid) chk("drain_order", out_data, sb.pop_front());
         tick();
      end
      chk("drain_empty", 32'(sb.size()), 32'h0);
      chk("final_idle", 32'(out_valid), 32'h0);
      chk("final_errs", 32'(err_count), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
